// File: rtl/codec_init_seq.sv
// WM8731 power-up sequencer: walks a fixed register table, one i2c_write handshake per entry.
// Optional macro CODEC_VOLUME_EN adds a post-init headphone volume rewrite (R2/R3).
module codec_init_seq #(
   parameter logic [7:0]  DEV_ADDR       = 8'h34,
   parameter int unsigned SETTLE_CYCLES  = 50_000,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       start,
`ifdef CODEC_VOLUME_EN
   input  logic       vol_set,
   input  logic [6:0] vol,
`endif
   output logic [7:0] i2c_addr,
   output logic [7:0] i2c_register,
   output logic [7:0] i2c_data,
   output logic       i2c_write,
   input  logic       i2c_done,
   output logic       busy,
   output logic       init_done,
   output logic       error,
   output logic [3:0] step
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_REQ, S_REL, S_SETTLE, S_DONE, S_ERROR
   } state_t;

   localparam logic [31:0] SETTLE_LIM  = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES - 1);

   // Table entry as {reg[6:0], val[8:0]}.
   function automatic logic [15:0] f_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    f_entry = {7'd15, 9'h000};
         4'd1:    f_entry = {7'd0,  9'h017};
         4'd2:    f_entry = {7'd1,  9'h017};
         4'd3:    f_entry = {7'd2,  9'h079};
         4'd4:    f_entry = {7'd3,  9'h079};
         4'd5:    f_entry = {7'd4,  9'h012};
         4'd6:    f_entry = {7'd5,  9'h000};
         4'd7:    f_entry = {7'd6,  9'h000};
         4'd8:    f_entry = {7'd7,  9'h00A};
         4'd9:    f_entry = {7'd9,  9'h001};
         default: f_entry = 16'h0000;
      endcase
   endfunction

   state_t      r_state, w_state_nx;
   logic [3:0]  r_step, w_step_nx;
   logic [31:0] r_cnt, w_cnt_nx;
   logic        r_init_done, w_init_done_nx;
   logic        r_error, w_error_nx;
   logic        r_auto_pend;
   logic        r_i2c_write;
   logic        r_busy;
   logic [15:0] r_word, w_word_nx;
   logic        w_last;
`ifdef CODEC_VOLUME_EN
   logic [6:0]  r_vol, w_vol_nx;
`endif

   // Next-state, step, counter and status decode.
   always_comb begin
      w_state_nx     = r_state;
      w_step_nx      = r_step;
      w_cnt_nx       = r_cnt;
      w_init_done_nx = r_init_done;
      w_error_nx     = r_error;
`ifdef CODEC_VOLUME_EN
      w_vol_nx       = r_vol;
      w_last         = (r_step == 4'd9) || (r_step == 4'd11);
`else
      w_last         = (r_step == 4'd9);
`endif
      case (r_state)
         S_IDLE: begin
            if (start || (AUTO_START && r_auto_pend)) begin
               w_state_nx = S_LOAD;
               w_step_nx  = 4'd0;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_LOAD: begin
            w_state_nx = S_REQ;
            w_cnt_nx   = 32'd0;
         end
         S_REQ: begin
            if (i2c_done) begin
               w_state_nx = S_REL;
               w_cnt_nx   = 32'd0;
            end else if (r_cnt >= TIMEOUT_LIM) begin
               w_state_nx = S_ERROR;
               w_error_nx = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + 32'd1;
            end
         end
         S_REL: begin
            if (!i2c_done) begin
               if (r_step == 4'd0) begin
                  w_state_nx = S_SETTLE;
                  w_cnt_nx   = 32'd0;
               end else if (w_last) begin
                  w_state_nx     = S_DONE;
                  w_init_done_nx = 1'b1;
               end else begin
                  w_state_nx = S_LOAD;
                  w_step_nx  = r_step + 4'd1;
               end
            end else if (r_cnt >= TIMEOUT_LIM) begin
               w_state_nx = S_ERROR;
               w_error_nx = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + 32'd1;
            end
         end
         S_SETTLE: begin
            if (r_cnt >= SETTLE_LIM) begin
               w_state_nx = S_LOAD;
               w_step_nx  = 4'd1;
            end else begin
               w_cnt_nx = r_cnt + 32'd1;
            end
         end
         S_DONE: begin
            if (start) begin
               w_state_nx     = S_LOAD;
               w_step_nx      = 4'd0;
               w_init_done_nx = 1'b0;
`ifdef CODEC_VOLUME_EN
            end else if (vol_set) begin
               w_state_nx     = S_LOAD;
               w_step_nx      = 4'd10;
               w_init_done_nx = 1'b0;
               w_vol_nx       = vol;
`endif
            end else begin
               w_state_nx = S_DONE;
            end
         end
         S_ERROR: begin
            if (start) begin
               w_state_nx = S_LOAD;
               w_step_nx  = 4'd0;
               w_error_nx = 1'b0;
            end else begin
               w_state_nx = S_ERROR;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Register word presented to i2c_write for the upcoming step.
   always_comb begin
      w_word_nx = f_entry(w_step_nx);
`ifdef CODEC_VOLUME_EN
      if (w_step_nx == 4'd10) begin
         w_word_nx = {7'd2, 2'b00, w_vol_nx};
      end else if (w_step_nx == 4'd11) begin
         w_word_nx = {7'd3, 2'b00, w_vol_nx};
      end else begin
         w_word_nx = f_entry(w_step_nx);
      end
`endif
   end

   // State, counters and registered outputs; rst drops i2c_write on the same edge.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_step      <= 4'd0;
         r_cnt       <= 32'd0;
         r_init_done <= 1'b0;
         r_error     <= 1'b0;
         r_auto_pend <= 1'b1;
         r_i2c_write <= 1'b0;
         r_busy      <= 1'b0;
         r_word      <= f_entry(4'd0);
`ifdef CODEC_VOLUME_EN
         r_vol       <= 7'd0;
`endif
      end else begin
         r_state     <= w_state_nx;
         r_step      <= w_step_nx;
         r_cnt       <= w_cnt_nx;
         r_init_done <= w_init_done_nx;
         r_error     <= w_error_nx;
         r_auto_pend <= 1'b0;
         r_i2c_write <= (w_state_nx == S_REQ);
         r_busy      <= (w_state_nx inside {S_LOAD, S_REQ, S_REL, S_SETTLE});
         r_word      <= w_word_nx;
`ifdef CODEC_VOLUME_EN
         r_vol       <= w_vol_nx;
`endif
      end
   end

   assign i2c_addr     = DEV_ADDR;
   assign i2c_register = r_word[15:8];
   assign i2c_data     = r_word[7:0];
   assign i2c_write    = r_i2c_write;
   assign busy         = r_busy;
   assign init_done    = r_init_done;
   assign error        = r_error;
   assign step         = r_step;

endmodule

// File: tb/tb_codec_init_seq.sv
// Scoreboard bench for codec_init_seq: stimulus queues expected writes, a monitor checks each write.
module tb_codec_init_seq;

   localparam int SETTLE = 400;
   localparam int TMO    = 300;
   localparam int BUDGET = 3000;

   logic       sys_clk = 1'b0;
   logic       rst     = 1'b1;
   logic       start   = 1'b0;
   logic [7:0] i2c_addr, i2c_register, i2c_data;
   logic       i2c_write;
   logic       i2c_done = 1'b0;
   logic       busy, init_done, error;
   logic [3:0] step;
`ifdef CODEC_VOLUME_EN
   logic       vol_set = 1'b0;
   logic [6:0] vol     = 7'd0;
`endif

   typedef struct {
      logic [3:0] idx;
      logic [7:0] rg;
      logic [7:0] dt;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         cyc      = 0;
   logic [3:0] hang_step = 4'd15;
   int         hi_cnt = 0;
   int         lo_cnt = 0;

   logic [15:0] tbl [10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                             16'h0812, 16'h0A00, 16'h0C00, 16'h0E0A, 16'h1201};

   codec_init_seq #(
      .DEV_ADDR(8'h34), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .start(start),
`ifdef CODEC_VOLUME_EN
      .vol_set(vol_set), .vol(vol),
`endif
      .i2c_addr(i2c_addr), .i2c_register(i2c_register), .i2c_data(i2c_data),
      .i2c_write(i2c_write), .i2c_done(i2c_done), .busy(busy),
      .init_done(init_done), .error(error), .step(step)
   );

   always #10 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Slave: done 3 cycles after write rises, drops 2 cycles after write falls; hangs on hang_step.
   always @(posedge sys_clk) begin
      if (rst) begin
         hi_cnt <= 0; lo_cnt <= 0; i2c_done <= 1'b0;
      end else if (i2c_write) begin
         lo_cnt <= 0;
         hi_cnt <= hi_cnt + 1;
         if (hi_cnt >= 2 && step != hang_step) i2c_done <= 1'b1;
      end else begin
         hi_cnt <= 0;
         if (i2c_done) begin
            lo_cnt <= lo_cnt + 1;
            if (lo_cnt >= 1) i2c_done <= 1'b0;
         end else begin
            lo_cnt <= 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
   endtask

   task automatic push_run(input int first, input int last);
      exp_t e;
      for (int i = first; i <= last; i++) begin
         e.idx = 4'(i);
         e.rg  = tbl[i][15:8];
         e.dt  = tbl[i][7:0];
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!init_done && n < BUDGET) begin
         @(negedge sys_clk);
         n++;
      end
      check(name, init_done, 1'b1);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_error"}, error, 1'b0);
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic wait_req(input logic [3:0] s, input string name);
      int n = 0;
      while (!(i2c_write && step == s) && n < BUDGET) begin
         @(negedge sys_clk);
         n++;
      end
      check(name, (i2c_write && step == s), 1'b1);
   endtask

   // Monitor: pops one expectation per write rise, checks register word stability until REL exits.
   initial begin : monitor
      logic        prev_wr;
      logic        active;
      logic        stable;
      logic [15:0] cap;
      logic [3:0]  cap_idx;
      int          close0;
      exp_t        e;
      prev_wr = 1'b0; active = 1'b0; stable = 1'b1; cap = 16'h0; cap_idx = 4'd0; close0 = -1;
      forever begin
         @(negedge sys_clk);
         if (rst) begin
            active  = 1'b0;
            prev_wr = 1'b0;
         end else begin
            if (i2c_write && !prev_wr) begin
               check("write_expected", (exp_q.size() != 0), 1'b1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("step_at_write", step, e.idx);
                  check("reg_at_write", i2c_register, e.rg);
                  check("data_at_write", i2c_data, e.dt);
                  check("addr_at_write", i2c_addr, 8'h34);
                  if (e.idx == 4'd1 && close0 >= 0)
                     check("settle_gap", ((cyc - close0) >= SETTLE), 1'b1);
                  cap     = {i2c_register, i2c_data};
                  cap_idx = e.idx;
                  active  = 1'b1;
                  stable  = 1'b1;
               end
            end else if (active) begin
               if ({i2c_register, i2c_data} != cap) stable = 1'b0;
               if (!i2c_write && !i2c_done) begin
                  check("word_stable", stable, 1'b1);
                  if (cap_idx == 4'd0) close0 = cyc;
                  active = 1'b0;
               end
            end
            prev_wr = i2c_write;
         end
      end
   end

   initial begin : stimulus
      int n;
      // Reset values
      repeat (3) @(negedge sys_clk);
      check("rst_write", i2c_write, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_init_done", init_done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_step", step, 4'd0);
      check("rst_word", {i2c_register, i2c_data}, 16'h1E00);
      check("rst_addr", i2c_addr, 8'h34);

      // Auto-start run, with a start pulse mid-sequence that must be ignored
      push_run(0, 9);
      rst = 1'b0;
      wait_req(4'd3, "reach_step3");
      pulse_start();
      check("start_busy_ignored", busy, 1'b1);
      wait_done("autostart_done");

      // start in DONE reruns the table
      push_run(0, 9);
      pulse_start();
      check("restart_init_drop", init_done, 1'b0);
      check("restart_busy", busy, 1'b1);
      check("restart_step", step, 4'd0);
      wait_done("restart_done");

      // Slave hangs on entry 5 -> timeout
      hang_step = 4'd5;
      push_run(0, 5);
      pulse_start();
      wait_req(4'd5, "reach_step5");
      n = 0;
      while (!error && n < TMO + 50) begin
         @(negedge sys_clk);
         n++;
      end
      check("timeout_cycles", n, TMO);
      check("err_step", step, 4'd5);
      check("err_write", i2c_write, 1'b0);
      check("err_busy", busy, 1'b0);
      check("err_drained", exp_q.size(), 0);
      hang_step = 4'd15;
      push_run(0, 9);
      pulse_start();
      check("err_cleared", error, 1'b0);
      wait_done("after_error_done");

      // rst during REQ of entry 4
      push_run(0, 4);
      pulse_start();
      wait_req(4'd4, "reach_step4");
      @(negedge sys_clk);
      rst = 1'b1;
      @(negedge sys_clk);
      check("midrst_write", i2c_write, 1'b0);
      check("midrst_step", step, 4'd0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_drained", exp_q.size(), 0);
      push_run(0, 9);
      @(negedge sys_clk);
      rst = 1'b0;
      wait_done("after_rst_done");

`ifdef CODEC_VOLUME_EN
      // Volume rewrite from DONE
      begin
         exp_t e;
         e.idx = 4'd10; e.rg = 8'h04; e.dt = 8'h70; exp_q.push_back(e);
         e.idx = 4'd11; e.rg = 8'h06; e.dt = 8'h70; exp_q.push_back(e);
      end
      vol     = 7'h70;
      vol_set = 1'b1;
      @(negedge sys_clk);
      vol_set = 1'b0;
      check("vol_init_drop", init_done, 1'b0);
      check("vol_busy", busy, 1'b1);
      check("vol_step", step, 4'd10);
      wait_done("vol_done");
`endif

      repeat (5) @(negedge sys_clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
